// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display scanout, host accesses and a
// full-RAM fill share one synchronous RAM port under fixed priority
// (display > host > fill).
module vram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_W-1:0] CLR_LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] fill_val;
    logic              host_pend;
    logic              host_pend_rd;
    logic              busy_q;
    logic              done_q;

    logic              host_issue;
    logic              clr_write;

    // Grant decision for the current cycle; reset blocks every requester.
    always_comb begin
        host_issue = host_req && !disp_req && !host_pend && !reset;
        clr_write  = (state == CLEAR) && !disp_req && !host_issue && !reset;
    end

    // Drive the RAM port from whichever requester owns it this cycle.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        if (!reset) begin
            if (disp_req) begin
                ram_addr = disp_addr;
            end else if (host_issue) begin
                ram_addr = host_addr;
                ram_din  = host_wdata;
                ram_we   = host_we;
            end else if (clr_write) begin
                ram_addr = clr_cnt;
                ram_din  = fill_val;
                ram_we   = 1'b1;
            end
        end
    end

    // Fill FSM plus host completion tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            fill_val     <= '0;
            host_pend    <= 1'b0;
            host_pend_rd <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            host_pend    <= host_issue;
            host_pend_rd <= host_issue && !host_we;
            done_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        fill_val <= clr_value;
                        busy_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_write) begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                        if (clr_cnt == CLR_LAST) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs; masked by reset so an aborted access never acks.
    always_comb begin
        disp_data  = ram_dout;
        host_ack   = host_pend && !reset;
        host_rdata = (host_pend_rd && !reset) ? ram_dout : '0;
        clr_busy   = busy_q && !reset;
        clr_done   = done_q && !reset;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, a transaction-level reference
// model (shadow memory + pending-event flags) and per-feature scenarios.
module tb_vram_arbiter;

    logic       clk = 1'b0;
    logic       reset, preload;
    logic       disp_req, host_req, host_we, clr_start;
    logic [9:0] disp_addr, host_addr;
    logic [7:0] host_wdata, clr_value;
    logic [7:0] disp_data, host_rdata, ram_din, ram_dout;
    logic       host_ack, clr_busy, clr_done, ram_we;
    logic [9:0] ram_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    function automatic logic [7:0] init_pat(input logic [9:0] a);
        return a[7:0] ^ {6'd0, a[9:8]} ^ 8'h5A;
    endfunction

    // Synchronous RAM, one-cycle read latency, optional bulk preload.
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_pat(10'(i));
        end else if (ram_we) begin
            ram[ram_addr] <= ram_din;
        end
        ram_dout <= ram[ram_addr];
    end

    // ---------------- reference model ----------------
    logic [7:0]  shadow [0:1023];
    bit          m_clearing, m_ack, m_ack_rd, m_done, m_disp_valid;
    int unsigned m_next;
    logic [7:0]  m_fill, m_ack_val, m_disp_val;

    bit          e_grant, e_we, e_ack, e_done, e_busy, e_disp_valid;
    logic [9:0]  e_addr;
    logic [7:0]  e_din, e_rdata, e_disp;

    task automatic model_step();
        bit was_clearing;
        e_grant = 0; e_we = 0; e_addr = '0; e_din = '0;
        e_ack = m_ack;
        e_rdata = m_ack_rd ? m_ack_val : 8'h00;
        e_done = m_done;
        e_busy = m_clearing;
        e_disp_valid = m_disp_valid;
        e_disp = m_disp_val;
        was_clearing = m_clearing;
        m_ack = 0; m_ack_rd = 0; m_done = 0; m_disp_valid = 0;
        if (reset) begin
            e_ack = 0; e_rdata = 8'h00; e_done = 0; e_busy = 0;
            m_clearing = 0; m_next = 0;
            return;
        end
        if (disp_req) begin
            e_grant = 1; e_addr = disp_addr;
            m_disp_valid = 1; m_disp_val = shadow[disp_addr];
        end else if (host_req && !e_ack) begin
            e_grant = 1; e_we = host_we; e_addr = host_addr; e_din = host_wdata;
            if (host_we) shadow[host_addr] = host_wdata;
            else m_ack_val = shadow[host_addr];
            m_ack = 1; m_ack_rd = !host_we;
        end else if (was_clearing) begin
            e_grant = 1; e_we = 1; e_addr = 10'(m_next); e_din = m_fill;
            shadow[10'(m_next)] = m_fill;
            if (m_next == 1023) begin
                m_clearing = 0; m_done = 1;
            end else begin
                m_next++;
            end
        end
        if (!was_clearing && clr_start) begin
            m_clearing = 1; m_next = 0; m_fill = clr_value;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_req = 0; host_req = 0; host_we = 0; clr_start = 0; reset = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1; preload = 1; disp_req = 1; disp_addr = 10'h0AA;
        host_req = 1; host_we = 1; host_addr = 10'h155; host_wdata = 8'hFF;
        clr_start = 1; clr_value = 8'h42;
        for (int i = 0; i < 2; i++) begin
            #1 model_step();
            n_tests++;
            if ({ram_we, ram_addr, ram_din, host_ack, host_rdata, clr_busy, clr_done} !== 30'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got we=%0b addr=%h din=%h ack=%0b rdata=%h busy=%0b done=%0b want all zero",
                         ram_we, ram_addr, ram_din, host_ack, host_rdata, clr_busy, clr_done);
            end
            tick();
            preload = 0;
        end
        idle();
        #1 model_step();
        n_tests++;
        if ({ram_we, host_ack, clr_busy, clr_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: got we=%0b ack=%0b busy=%0b done=%0b want 0000",
                     ram_we, host_ack, clr_busy, clr_done);
        end
        tick();
    endtask

    task automatic test_host_rw();
        idle();
        #1 model_step(); tick();
        host_req = 1; host_we = 1; host_addr = 10'h041; host_wdata = 8'h3A;
        #1 model_step();
        n_tests++;
        if ({ram_we, ram_addr, ram_din, host_ack} !== {1'b1, 10'h041, 8'h3A, 1'b0}) begin
            n_fail++;
            $display("FAIL host_wr_issue: got we=%0b addr=%h din=%h ack=%0b want 1 041 3a 0",
                     ram_we, ram_addr, ram_din, host_ack);
        end
        tick();
        #1 model_step();
        n_tests++;
        if ({host_ack, ram_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL host_wr_ack: got ack=%0b we=%0b want ack=1 we=0", host_ack, ram_we);
        end
        tick();
        host_req = 0;
        #1 model_step(); tick();
        host_req = 1; host_we = 0;
        #1 model_step();
        n_tests++;
        if ({ram_we, ram_addr, host_ack} !== {1'b0, 10'h041, 1'b0}) begin
            n_fail++;
            $display("FAIL host_rd_issue: got we=%0b addr=%h ack=%0b want 0 041 0", ram_we, ram_addr, host_ack);
        end
        tick();
        #1 model_step();
        n_tests++;
        if ({host_ack, host_rdata} !== {1'b1, 8'h3A}) begin
            n_fail++;
            $display("FAIL host_rd_ack: got ack=%0b rdata=%h want ack=1 rdata=3a", host_ack, host_rdata);
        end
        tick();
        host_req = 0;
        #1 model_step();
        n_tests++;
        if ({host_ack, host_rdata} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL host_ack_pulse: got ack=%0b rdata=%h want ack=0 rdata=00", host_ack, host_rdata);
        end
        tick();
    endtask

    task automatic test_disp_block();
        idle();
        #1 model_step(); tick();
        host_req = 1; host_we = 0; host_addr = 10'($urandom); disp_req = 1;
        for (int i = 0; i < 8; i++) begin
            disp_addr = 10'($urandom);
            #1 model_step();
            n_tests++;
            if (ram_we !== 1'b0 || host_ack !== 1'b0 || ram_addr !== disp_addr) begin
                n_fail++;
                $display("FAIL disp_block[%0d]: got we=%0b ack=%0b addr=%h want 0 0 %h",
                         i, ram_we, host_ack, ram_addr, disp_addr);
            end
            if (e_disp_valid) begin
                n_tests++;
                if (disp_data !== e_disp) begin
                    n_fail++;
                    $display("FAIL disp_data[%0d]: got %h want %h", i, disp_data, e_disp);
                end
            end
            tick();
        end
        disp_req = 0;
        #1 model_step();
        n_tests++;
        if ({ram_addr, host_ack} !== {host_addr, 1'b0}) begin
            n_fail++;
            $display("FAIL disp_release_issue: got addr=%h ack=%0b want %h 0", ram_addr, host_ack, host_addr);
        end
        n_tests++;
        if (disp_data !== e_disp) begin
            n_fail++;
            $display("FAIL disp_data_last: got %h want %h", disp_data, e_disp);
        end
        tick();
        #1 model_step();
        n_tests++;
        if ({host_ack, host_rdata} !== {1'b1, e_rdata}) begin
            n_fail++;
            $display("FAIL disp_release_ack: got ack=%0b rdata=%h want 1 %h", host_ack, host_rdata, e_rdata);
        end
        tick();
        idle();
    endtask

    task automatic test_clear_basic();
        logic [9:0] a;
        idle();
        #1 model_step(); tick();
        clr_start = 1; clr_value = 8'h00;
        #1 model_step();
        n_tests++;
        if ({clr_busy, ram_we} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_start_cycle: got busy=%0b we=%0b want 0 0", clr_busy, ram_we);
        end
        tick();
        clr_start = 0;
        for (int k = 0; k < 1024; k++) begin
            a = 10'(k);
            #1 model_step();
            n_tests++;
            if ({ram_we, ram_addr, ram_din, clr_busy, clr_done} !== {1'b1, a, 8'h00, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL clr_write[%0d]: got we=%0b addr=%h din=%h busy=%0b done=%0b want 1 %h 00 1 0",
                         k, ram_we, ram_addr, ram_din, clr_busy, clr_done, a);
            end
            tick();
        end
        #1 model_step();
        n_tests++;
        if ({clr_done, clr_busy, ram_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL clr_done_1025: got done=%0b busy=%0b we=%0b want 1 0 0", clr_done, clr_busy, ram_we);
        end
        tick();
        #1 model_step();
        n_tests++;
        if (clr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_done_pulse: got %0b want 0", clr_done);
        end
        tick();
        for (int i = 0; i <= 1024; i++) begin
            disp_req = (i < 1024);
            disp_addr = 10'(i);
            #1 model_step();
            if (i > 0) begin
                n_tests++;
                if (disp_data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL clr_readback[%0d]: got %h want 00", i - 1, disp_data);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_clear_disp();
        bit exp_we;
        idle();
        clr_start = 1; clr_value = 8'hA5;
        #1 model_step(); tick();
        clr_start = 0;
        for (int i = 1; i <= 2049; i++) begin
            disp_req = (i % 2 == 1) && (i < 2049);
            disp_addr = 10'($urandom);
            exp_we = (i <= 2048) && (i % 2 == 0);
            #1 model_step();
            n_tests++;
            if (ram_we !== exp_we || clr_done !== (i == 2049) || (exp_we && ram_addr !== 10'(i / 2 - 1))) begin
                n_fail++;
                $display("FAIL clr_alt[%0d]: got we=%0b done=%0b addr=%h want we=%0b done=%0b addr=%h",
                         i, ram_we, clr_done, ram_addr, exp_we, (i == 2049), 10'(i / 2 - 1));
            end
            if (e_disp_valid) begin
                n_tests++;
                if (disp_data !== e_disp) begin
                    n_fail++;
                    $display("FAIL clr_alt_disp[%0d]: got %h want %h", i, disp_data, e_disp);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midfill();
        idle();
        clr_start = 1; clr_value = 8'h5C;
        #1 model_step(); tick();
        clr_start = 0;
        for (int i = 1; i <= 512; i++) begin
            #1 model_step(); tick();
        end
        reset = 1;
        #1 model_step();
        n_tests++;
        if ({ram_we, clr_busy, clr_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_fill_cycle: got we=%0b busy=%0b done=%0b want 000", ram_we, clr_busy, clr_done);
        end
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            #1 model_step();
            n_tests++;
            if ({ram_we, clr_busy, clr_done} !== 3'b000) begin
                n_fail++;
                $display("FAIL rst_fill_after[%0d]: got we=%0b busy=%0b done=%0b want 000",
                         i, ram_we, clr_busy, clr_done);
            end
            tick();
        end
        for (int i = 0; i <= 1024; i++) begin
            disp_req = (i < 1024);
            disp_addr = 10'(i);
            #1 model_step();
            if (i > 0) begin
                n_tests++;
                if (disp_data !== ((i - 1 < 512) ? 8'h5C : 8'hA5)) begin
                    n_fail++;
                    $display("FAIL rst_fill_mem[%0d]: got %h want %h", i - 1, disp_data,
                             ((i - 1 < 512) ? 8'h5C : 8'hA5));
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_restart_ignored();
        int writes = 0, bad = 0, dones = 0, done_at = 0;
        idle();
        clr_start = 1; clr_value = 8'h11;
        #1 model_step(); tick();
        clr_start = 0;
        for (int i = 1; i <= 1026; i++) begin
            clr_start = (i == 300);
            clr_value = (i == 300) ? 8'h77 : 8'h11;
            #1 model_step();
            if (ram_we) begin
                if (ram_addr !== 10'(writes) || ram_din !== 8'h11) bad++;
                writes++;
            end
            if (clr_done) begin
                dones++;
                done_at = i;
            end
            tick();
        end
        clr_start = 0;
        n_tests++;
        if (writes != 1024 || bad != 0) begin
            n_fail++;
            $display("FAIL restart_writes: got %0d writes %0d bad want 1024 writes 0 bad", writes, bad);
        end
        n_tests++;
        if (dones != 1 || done_at != 1025) begin
            n_fail++;
            $display("FAIL restart_done: got %0d pulses at %0d want 1 pulse at 1025", dones, done_at);
        end
    endtask

    task automatic test_random();
        bit last_ack = 0;
        idle();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 799) == 0);
            disp_req = ($urandom_range(0, 2) == 0);
            disp_addr = 10'($urandom);
            clr_start = ($urandom_range(0, 399) == 0);
            clr_value = 8'($urandom);
            if (!host_req || last_ack) begin
                host_req = $urandom_range(0, 1) == 1;
                host_we = $urandom_range(0, 1) == 1;
                host_addr = 10'($urandom);
                host_wdata = 8'($urandom);
            end
            #1 model_step();
            last_ack = e_ack;
            n_tests++;
            if (ram_we !== e_we || (e_grant && ram_addr !== e_addr) || (e_we && ram_din !== e_din)) begin
                n_fail++;
                $display("FAIL rand_port[%0d]: got we=%0b addr=%h din=%h want we=%0b addr=%h din=%h",
                         c, ram_we, ram_addr, ram_din, e_we, e_addr, e_din);
            end
            n_tests++;
            if (host_ack !== e_ack || host_rdata !== e_rdata) begin
                n_fail++;
                $display("FAIL rand_host[%0d]: got ack=%0b rdata=%h want ack=%0b rdata=%h",
                         c, host_ack, host_rdata, e_ack, e_rdata);
            end
            n_tests++;
            if (clr_busy !== e_busy || clr_done !== e_done) begin
                n_fail++;
                $display("FAIL rand_clear[%0d]: got busy=%0b done=%0b want busy=%0b done=%0b",
                         c, clr_busy, clr_done, e_busy, e_done);
            end
            if (e_disp_valid) begin
                n_tests++;
                if (disp_data !== e_disp) begin
                    n_fail++;
                    $display("FAIL rand_disp[%0d]: got %h want %h", c, disp_data, e_disp);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_pat(10'(i));
        m_clearing = 0; m_ack = 0; m_ack_rd = 0; m_done = 0; m_disp_valid = 0;
        m_next = 0; m_fill = '0; m_ack_val = '0; m_disp_val = '0;
        preload = 0; host_wdata = '0; clr_value = '0; disp_addr = '0; host_addr = '0;
        test_reset();
        test_host_rw();
        test_disp_block();
        test_clear_basic();
        test_clear_disp();
        test_reset_midfill();
        test_restart_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
